ring_nic: RTL and testbench

Processor-side network interface for the ring router's PE port. Accepts 64-bit packets from the local processor through a small register-mapped port and injects them into the router's PE input channel on the correct even/odd virtual-channel cycle. Ejects packets the router delivers on its PE output into a one-entry receive buffer that the processor polls and reads. Keeps wrap-around traffic and drop counters.

---
 rtl/ring_nic.sv | 157 +++++++++++++++
 tb/tb_ring_nic.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_nic.sv
// ----------------------------------------------------------------------------
// ring_nic
//
// Processor-side network interface for the ring router's PE port.
// The processor writes one 64-bit packet at a time into a single-entry
// transmit buffer. The packet is handed to the router only on a cycle whose
// ring polarity matches its virtual channel. Packets that the router delivers
// land in a single-entry receive buffer. The processor polls that buffer and
// reads it out. Three 16-bit wrap-around counters track sent packets,
// received packets and dropped writes.
//
// Ports
//   clk           single clock, rising edge
//   reset         synchronous, active-high
//   addr[2:0]     processor register address
//   d_in[63:0]    processor write data
//   d_out[63:0]   processor read data (combinational, 0 unless reading)
//   nicEn         processor access enable
//   nicWrEn       1 = write, 0 = read (qualified by nicEn)
//   net_polarity  ring polarity, shared with the router
//   net_so        send to router PE input
//   net_ro        router PE input ready
//   net_do[63:0]  packet to router
//   net_si        router PE output send
//   net_ri        ready to router PE output
//   net_di[63:0]  packet from router
//
// Register map (reads)
//   0 rx_buf (read drains the buffer)   1 rx_full     2 tx_buf
//   3 tx_full   4 tx_cnt   5 rx_cnt   6 drop_cnt   7 zero
// Writes: 2 loads tx_buf, 7 clears all counters, others are ignored.
// ----------------------------------------------------------------------------
module ring_nic (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  addr,
   input  logic [63:0] d_in,
   output logic [63:0] d_out,
   input  logic        nicEn,
   input  logic        nicWrEn,
   input  logic        net_polarity,
   output logic        net_so,
   input  logic        net_ro,
   output logic [63:0] net_do,
   input  logic        net_si,
   output logic        net_ri,
   input  logic [63:0] net_di
);

   localparam logic [2:0] ADDR_RX_BUF   = 3'd0;
   localparam logic [2:0] ADDR_RX_STAT  = 3'd1;
   localparam logic [2:0] ADDR_TX_BUF   = 3'd2;
   localparam logic [2:0] ADDR_TX_STAT  = 3'd3;
   localparam logic [2:0] ADDR_TX_CNT   = 3'd4;
   localparam logic [2:0] ADDR_RX_CNT   = 3'd5;
   localparam logic [2:0] ADDR_DROP_CNT = 3'd6;
   localparam logic [2:0] ADDR_CLEAR    = 3'd7;

   logic [63:0] tx_buf;
   logic [63:0] rx_buf;
   logic        tx_full;
   logic        rx_full;
   logic [15:0] tx_cnt;
   logic [15:0] rx_cnt;
   logic [15:0] drop_cnt;

   logic cpu_wr;
   logic cpu_rd;
   logic tx_write;
   logic tx_load;
   logic tx_drop;
   logic tx_eligible;
   logic rx_accept;
   logic rx_drain;
   logic cnt_clear;

   assign cpu_wr    = nicEn & nicWrEn;
   assign cpu_rd    = nicEn & ~nicWrEn;
   assign tx_write  = cpu_wr & (addr == ADDR_TX_BUF);
   assign tx_load   = tx_write & ~tx_full;
   assign tx_drop   = tx_write & tx_full;
   assign cnt_clear = cpu_wr & (addr == ADDR_CLEAR);

   // An even-VC packet (bit 63 = 0) may only go out while polarity is 1,
   // and an odd-VC packet only while polarity is 0. This matches the cycle
   // on which the router latches that VC from its PE input.
   assign tx_eligible = tx_full & (net_polarity != tx_buf[63]);
   assign net_so      = tx_eligible & net_ro;
   assign net_do      = tx_buf;

   assign net_ri    = ~rx_full;
   assign rx_accept = net_si & net_ri;
   assign rx_drain  = cpu_rd & (addr == ADDR_RX_BUF) & rx_full;

   // Transmit buffer. Load and send can never coincide: a load needs an
   // empty buffer and a send needs a full one. A write that arrives in the
   // same cycle as a send therefore sees the buffer as full and is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_buf  <= '0;
         tx_full <= 1'b0;
      end else if (net_so) begin
         tx_full <= 1'b0;
      end else if (tx_load) begin
         tx_buf  <= d_in;
         tx_full <= 1'b1;
      end
   end

   // Receive buffer. An arrival needs net_ri, which means the buffer is
   // empty. A drain needs the buffer to be full. The two are exclusive.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_buf  <= '0;
         rx_full <= 1'b0;
      end else if (rx_accept) begin
         rx_buf  <= net_di;
         rx_full <= 1'b1;
      end else if (rx_drain) begin
         rx_full <= 1'b0;
      end
   end

   // Traffic counters. They wrap naturally at 16 bits. A clear write takes
   // priority over any increment that happens in the same cycle.
   always_ff @(posedge clk) begin
      if (reset || cnt_clear) begin
         tx_cnt   <= '0;
         rx_cnt   <= '0;
         drop_cnt <= '0;
      end else begin
         if (net_so)    tx_cnt   <= tx_cnt + 16'd1;
         if (rx_accept) rx_cnt   <= rx_cnt + 16'd1;
         if (tx_drop)   drop_cnt <= drop_cnt + 16'd1;
      end
   end

   // Read mux. This is purely combinational, so read data is valid in the
   // same cycle as the access. The mux drives 0 whenever the processor is
   // not reading.
   always_comb begin
      d_out = '0;
      if (cpu_rd) begin
         case (addr)
            ADDR_RX_BUF:   d_out = rx_buf;
            ADDR_RX_STAT:  d_out = {63'b0, rx_full};
            ADDR_TX_BUF:   d_out = tx_buf;
            ADDR_TX_STAT:  d_out = {63'b0, tx_full};
            ADDR_TX_CNT:   d_out = {48'b0, tx_cnt};
            ADDR_RX_CNT:   d_out = {48'b0, rx_cnt};
            ADDR_DROP_CNT: d_out = {48'b0, drop_cnt};
            default:       d_out = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_ring_nic.sv
// ----------------------------------------------------------------------------
// tb_ring_nic
//
// Self-checking bench for ring_nic. Directed scenarios walk through reset,
// injection, backpressure/drop, receive/drain, counter wrap and clear, and
// reset with packets pending. A randomized run then compares every output
// against a behavioural model, once per cycle.
// ----------------------------------------------------------------------------
module tb_ring_nic;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  addr;
   logic [63:0] d_in;
   logic [63:0] d_out;
   logic        nicEn;
   logic        nicWrEn;
   logic        net_polarity;
   logic        net_so;
   logic        net_ro;
   logic [63:0] net_do;
   logic        net_si;
   logic        net_ri;
   logic [63:0] net_di;

   int n_vec  = 0;
   int n_miss = 0;

   // Behavioural model of the NIC, kept at the level of the register map.
   bit          m_tx_full;
   bit          m_rx_full;
   logic [63:0] m_tx_buf;
   logic [63:0] m_rx_buf;
   int          m_tx_cnt;
   int          m_rx_cnt;
   int          m_drop_cnt;

   ring_nic dut (
      .clk          (clk),
      .reset        (reset),
      .addr         (addr),
      .d_in         (d_in),
      .d_out        (d_out),
      .nicEn        (nicEn),
      .nicWrEn      (nicWrEn),
      .net_polarity (net_polarity),
      .net_so       (net_so),
      .net_ro       (net_ro),
      .net_do       (net_do),
      .net_si       (net_si),
      .net_ri       (net_ri),
      .net_di       (net_di)
   );

   always #5 clk = ~clk;

   // The send condition, stated directly: a packet is waiting, its VC bit
   // differs from the current polarity, and the router is ready.
   function automatic logic exp_so();
      return m_tx_full && (net_polarity != m_tx_buf[63]) && net_ro;
   endfunction

   function automatic logic [63:0] exp_dout();
      if (!nicEn || nicWrEn) return 64'd0;
      case (addr)
         3'd0:    return m_rx_buf;
         3'd1:    return 64'(m_rx_full);
         3'd2:    return m_tx_buf;
         3'd3:    return 64'(m_tx_full);
         3'd4:    return 64'(m_tx_cnt);
         3'd5:    return 64'(m_rx_cnt);
         3'd6:    return 64'(m_drop_cnt);
         default: return 64'd0;
      endcase
   endfunction

   // Advance the model by one clock using the inputs that are currently
   // driven, then step the DUT past the same edge.
   task automatic tick();
      bit so, wr, rd;
      so = exp_so();
      wr = nicEn && nicWrEn;
      rd = nicEn && !nicWrEn;
      if (reset) begin
         m_tx_full = 0; m_rx_full = 0; m_tx_buf = '0; m_rx_buf = '0;
         m_tx_cnt = 0; m_rx_cnt = 0; m_drop_cnt = 0;
      end else begin
         if (wr && addr == 3'd2) begin
            if (m_tx_full) m_drop_cnt = (m_drop_cnt + 1) % 65536;
            else begin m_tx_buf = d_in; m_tx_full = 1; end
         end
         if (so) begin
            m_tx_full = 0;
            m_tx_cnt  = (m_tx_cnt + 1) % 65536;
         end
         if (net_si && !m_rx_full) begin
            m_rx_buf  = net_di;
            m_rx_full = 1;
            m_rx_cnt  = (m_rx_cnt + 1) % 65536;
         end else if (rd && addr == 3'd0 && m_rx_full) begin
            m_rx_full = 0;
         end
         if (wr && addr == 3'd7) begin
            m_tx_cnt = 0; m_rx_cnt = 0; m_drop_cnt = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 0; nicEn = 0; nicWrEn = 0; addr = 3'd0; net_si = 0;
   endtask

   task automatic cpu_read(input logic [2:0] a);
      nicEn = 1; nicWrEn = 0; addr = a;
      #1;
   endtask

   task automatic cpu_write(input logic [2:0] a, input logic [63:0] v);
      nicEn = 1; nicWrEn = 1; addr = a; d_in = v;
   endtask

   task automatic test_reset();
      logic [2:0] regs [5] = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd6};
      reset = 1; nicEn = 0; nicWrEn = 0; addr = 0; d_in = '0;
      net_polarity = 0; net_ro = 0; net_si = 0; net_di = '0;
      tick();
      idle();
      #1;
      n_vec++; if (net_so !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_so: got %0b expected 0", net_so); end
      n_vec++; if (net_ri !== 1'b1) begin n_miss++; $display("[TB] FAIL reset_ri: got %0b expected 1", net_ri); end
      n_vec++; if (net_do !== 64'd0) begin n_miss++; $display("[TB] FAIL reset_do: got %h expected 0", net_do); end
      n_vec++; if (d_out !== 64'd0) begin n_miss++; $display("[TB] FAIL reset_dout_idle: got %h expected 0", d_out); end
      foreach (regs[i]) begin
         cpu_read(regs[i]);
         n_vec++; if (d_out !== 64'd0) begin n_miss++; $display("[TB] FAIL reset_reg%0d: got %h expected 0", regs[i], d_out); end
      end
      idle();
   endtask

   task automatic test_even_inject();
      logic [63:0] pkt = 64'h0000_0100_0000_00AA;
      net_ro = 1; net_polarity = 1;
      cpu_write(3'd2, pkt);
      tick();
      idle(); net_polarity = 0; #1;
      n_vec++; if (net_so !== 1'b0) begin n_miss++; $display("[TB] FAIL even_wait_so: got %0b expected 0", net_so); end
      tick();
      net_polarity = 1; #1;
      n_vec++; if (net_so !== 1'b1) begin n_miss++; $display("[TB] FAIL even_send_so: got %0b expected 1", net_so); end
      n_vec++; if (net_do !== pkt) begin n_miss++; $display("[TB] FAIL even_send_do: got %h expected %h", net_do, pkt); end
      tick();
      net_polarity = 0;
      cpu_read(3'd3);
      n_vec++; if (d_out !== 64'd0) begin n_miss++; $display("[TB] FAIL even_tx_full: got %h expected 0", d_out); end
      cpu_read(3'd4);
      n_vec++; if (d_out !== 64'd1) begin n_miss++; $display("[TB] FAIL even_tx_cnt: got %h expected 1", d_out); end
      idle();
   endtask

   task automatic test_backpressure_drop();
      logic [63:0] pkt = 64'h8000_0000_0000_0001;
      net_ro = 0;
      cpu_write(3'd2, pkt);
      tick();
      idle();
      for (int i = 0; i < 6; i++) begin
         net_polarity = ~net_polarity; #1;
         n_vec++; if (net_so !== 1'b0) begin n_miss++; $display("[TB] FAIL bp_hold_so%0d: got %0b expected 0", i, net_so); end
         tick();
      end
      cpu_write(3'd2, 64'h2);
      tick();
      cpu_read(3'd6);
      n_vec++; if (d_out !== 64'd1) begin n_miss++; $display("[TB] FAIL bp_drop_cnt: got %h expected 1", d_out); end
      cpu_read(3'd2);
      n_vec++; if (d_out !== pkt) begin n_miss++; $display("[TB] FAIL bp_tx_buf_kept: got %h expected %h", d_out, pkt); end
      idle();
      net_ro = 1; net_polarity = 1; #1;
      n_vec++; if (net_so !== 1'b0) begin n_miss++; $display("[TB] FAIL bp_odd_wrong_pol: got %0b expected 0", net_so); end
      tick();
      net_polarity = 0; #1;
      n_vec++; if (net_so !== 1'b1) begin n_miss++; $display("[TB] FAIL bp_odd_send_so: got %0b expected 1", net_so); end
      n_vec++; if (net_do !== pkt) begin n_miss++; $display("[TB] FAIL bp_odd_send_do: got %h expected %h", net_do, pkt); end
      tick();
      cpu_read(3'd4);
      n_vec++; if (d_out !== 64'd2) begin n_miss++; $display("[TB] FAIL bp_tx_cnt: got %h expected 2", d_out); end
      idle();
   endtask

   task automatic test_receive_drain();
      logic [63:0] pkt = 64'h4000_0000_DEAD_BEEF;
      idle(); #1;
      n_vec++; if (net_ri !== 1'b1) begin n_miss++; $display("[TB] FAIL rx_ready_empty: got %0b expected 1", net_ri); end
      net_si = 1; net_di = pkt;
      tick();
      net_si = 0; net_di = 64'h1234_5678_9ABC_DEF0; #1;
      n_vec++; if (net_ri !== 1'b0) begin n_miss++; $display("[TB] FAIL rx_ready_full: got %0b expected 0", net_ri); end
      cpu_read(3'd1);
      n_vec++; if (d_out !== 64'd1) begin n_miss++; $display("[TB] FAIL rx_full_stat: got %h expected 1", d_out); end
      // A router send during the drain cycle must be refused.
      net_si = 1;
      cpu_read(3'd0);
      n_vec++; if (d_out !== pkt) begin n_miss++; $display("[TB] FAIL rx_read_data: got %h expected %h", d_out, pkt); end
      tick();
      idle(); #1;
      n_vec++; if (net_ri !== 1'b1) begin n_miss++; $display("[TB] FAIL rx_ready_drained: got %0b expected 1", net_ri); end
      cpu_read(3'd5);
      n_vec++; if (d_out !== 64'd1) begin n_miss++; $display("[TB] FAIL rx_cnt: got %h expected 1", d_out); end
      cpu_read(3'd1);
      n_vec++; if (d_out !== 64'd0) begin n_miss++; $display("[TB] FAIL rx_no_arrival_on_drain: got %h expected 0", d_out); end
      idle();
   endtask

   task automatic test_counter_wrap();
      logic [63:0] want;
      logic [63:0] pkt = 64'h0000_0000_0000_0055;
      cpu_write(3'd7, 64'd0);
      tick();
      net_ro = 0;
      cpu_write(3'd2, pkt);
      tick();
      for (int i = 1; i <= 65537; i++) begin
         cpu_write(3'd2, 64'(i));
         tick();
         if (i >= 65535) begin
            want = (i == 65535) ? 64'hFFFF : 64'(i - 65536);
            cpu_read(3'd6);
            n_vec++; if (d_out !== want) begin n_miss++; $display("[TB] FAIL wrap_drop_cnt_%0d: got %h expected %h", i, d_out, want); end
         end
      end
      cpu_read(3'd2);
      n_vec++; if (d_out !== pkt) begin n_miss++; $display("[TB] FAIL wrap_tx_buf_kept: got %h expected %h", d_out, pkt); end
      // Clear in the same cycle as an arrival: the arrival lands, the count does not.
      cpu_write(3'd7, 64'd0);
      net_si = 1; net_di = 64'h0BAD_F00D_0000_0001;
      tick();
      net_si = 0;
      cpu_read(3'd5);
      n_vec++; if (d_out !== 64'd0) begin n_miss++; $display("[TB] FAIL clear_rx_cnt: got %h expected 0", d_out); end
      cpu_read(3'd6);
      n_vec++; if (d_out !== 64'd0) begin n_miss++; $display("[TB] FAIL clear_drop_cnt: got %h expected 0", d_out); end
      cpu_read(3'd1);
      n_vec++; if (d_out !== 64'd1) begin n_miss++; $display("[TB] FAIL clear_arrival_kept: got %h expected 1", d_out); end
      idle();
   endtask

   task automatic test_reset_mid();
      logic [2:0] regs [5] = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd6};
      // The buffered packet is even-VC, so polarity 0 keeps it from going out.
      idle();
      reset = 1; net_ro = 1; net_polarity = 0; #1;
      n_vec++; if (net_so !== 1'b0) begin n_miss++; $display("[TB] FAIL rst_mid_so_during: got %0b expected 0", net_so); end
      tick();
      reset = 0; net_polarity = 1; #1;
      n_vec++; if (net_so !== 1'b0) begin n_miss++; $display("[TB] FAIL rst_mid_so_after: got %0b expected 0", net_so); end
      n_vec++; if (net_ri !== 1'b1) begin n_miss++; $display("[TB] FAIL rst_mid_ri: got %0b expected 1", net_ri); end
      n_vec++; if (net_do !== 64'd0) begin n_miss++; $display("[TB] FAIL rst_mid_do: got %h expected 0", net_do); end
      foreach (regs[i]) begin
         cpu_read(regs[i]);
         n_vec++; if (d_out !== 64'd0) begin n_miss++; $display("[TB] FAIL rst_mid_reg%0d: got %h expected 0", regs[i], d_out); end
      end
      idle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         reset   = ($urandom_range(0, 99) == 0);
         nicEn   = $urandom_range(0, 1);
         nicWrEn = $urandom_range(0, 1);
         if (nicWrEn) addr = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
         else         addr = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
         d_in   = {$urandom, $urandom};
         net_di = {$urandom, $urandom};
         net_si = $urandom_range(0, 1);
         net_ro = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) net_polarity = $urandom_range(0, 1);
         else                           net_polarity = ~net_polarity;
         #1;
         n_vec++; if (net_so !== exp_so()) begin n_miss++; $display("[TB] FAIL rand_so_%0d: got %0b expected %0b", i, net_so, exp_so()); end
         n_vec++; if (net_ri !== !m_rx_full) begin n_miss++; $display("[TB] FAIL rand_ri_%0d: got %0b expected %0b", i, net_ri, !m_rx_full); end
         n_vec++; if (net_do !== m_tx_buf) begin n_miss++; $display("[TB] FAIL rand_do_%0d: got %h expected %h", i, net_do, m_tx_buf); end
         n_vec++; if (d_out !== exp_dout()) begin n_miss++; $display("[TB] FAIL rand_dout_%0d addr %0d: got %h expected %h", i, addr, d_out, exp_dout()); end
         tick();
      end
      idle();
   endtask

   initial begin
      $display("[TB] ring_nic bench start");
      test_reset();
      test_even_inject();
      test_backpressure_drop();
      test_receive_drain();
      test_counter_wrap();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
